// File: rtl/debug_uart_rx.sv
// debug_uart_rx: 8N1 UART receiver with a small receive FIFO and sticky error flags.
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   uart_rxd     asynchronous serial input, idle high
//   rd_pop       1-cycle pulse, pops the FIFO head
//   err_clr      1-cycle pulse, clears framing_err and overflow
//   rx_data      FIFO head byte, 8'h00 when empty
//   rx_valid     FIFO not empty (also the interrupt request)
//   rx_full      FIFO holds FIFO_DEPTH entries
//   framing_err  sticky: a stop bit was sampled low
//   overflow     sticky: a byte arrived while the FIFO was full
module debug_uart_rx #(
    parameter int CLK_HZ     = 27_000_000,
    parameter int BIT_RATE   = 1_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rd_pop,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       framing_err,
    output logic       overflow
);
    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int TW   = CPB > 1 ? $clog2(CPB) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t          r_state, w_state_nx;
    logic            r_s1, r_rxs;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_cnt;
    logic            r_ferr, r_ovf;
    logic            w_tmr_clr, w_shift_en, w_push, w_ferr_set;
    logic            w_half, w_bit, w_empty, w_full, w_pop, w_wr, w_ovf_set;

    assign w_half    = r_timer == TW'(HALF - 1);
    assign w_bit     = r_timer == TW'(CPB - 1);
    assign w_empty   = r_cnt == '0;
    assign w_full    = r_cnt == CW'(FIFO_DEPTH);
    assign w_pop     = rd_pop & ~w_empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    assign rx_data     = w_empty ? 8'h00 : r_mem[r_rp];
    assign rx_valid    = ~w_empty;
    assign rx_full     = w_full;
    assign framing_err = r_ferr;
    assign overflow    = r_ovf;

    always_comb begin
        w_state_nx = r_state;
        w_tmr_clr  = (r_state == S_IDLE) || (r_state == S_BREAK);
        w_shift_en = 1'b0;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        unique case (r_state)
            S_IDLE:  w_state_nx = r_rxs ? S_IDLE : S_START;
            S_START: if (w_half) begin
                w_tmr_clr  = 1'b1;
                w_state_nx = r_rxs ? S_IDLE : S_DATA;
            end
            S_DATA:  if (w_bit) begin
                w_tmr_clr  = 1'b1;
                w_shift_en = 1'b1;
                w_state_nx = r_idx == 3'd7 ? S_STOP : S_DATA;
            end
            S_STOP:  if (w_bit) begin
                w_tmr_clr  = 1'b1;
                w_push     = r_rxs;
                w_ferr_set = ~r_rxs;
                w_state_nx = r_rxs ? S_IDLE : S_BREAK;
            end
            S_BREAK: w_state_nx = r_rxs ? S_IDLE : S_BREAK;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_rxs   <= 1'b1;
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_s1    <= uart_rxd;
            r_rxs   <= r_s1;
            r_state <= w_state_nx;
            r_timer <= w_tmr_clr ? '0 : r_timer + 1'b1;
            r_idx   <= r_state == S_START ? '0 : w_shift_en ? r_idx + 1'b1 : r_idx;
            // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom.
            r_shift <= w_shift_en ? {r_rxs, r_shift[7:1]} : r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= r_shift;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_pop);
            // A new error in the same cycle as err_clr wins.
            r_ferr <= w_ferr_set | (r_ferr & ~err_clr);
            r_ovf  <= w_ovf_set | (r_ovf & ~err_clr);
        end
    end
endmodule

// File: tb/tb_debug_uart_rx.sv
// tb_debug_uart_rx: scoreboard bench for debug_uart_rx with a queue-based FIFO model.
`timescale 1ns/1ps
module tb_debug_uart_rx;
    localparam int CPB    = 27;
    localparam int HALF   = 13;
    localparam int DEPTH  = 4;
    localparam int T_STOP = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1, rd_pop = 1'b0, err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, framing_err, overflow;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] model_q[$];
    bit         exp_ferr = 1'b0, exp_ovf = 1'b0;

    always #5 clk = ~clk;

    debug_uart_rx dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rd_pop(rd_pop), .err_clr(err_clr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
        .framing_err(framing_err), .overflow(overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) exp_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input real cpb,
                              input int extra_low, input bit upd);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            idle(int'((i + 1) * cpb) - int'(i * cpb));
        end
        if (extra_low > 0) begin
            uart_rxd = 1'b0;
            idle(extra_low);
        end
        uart_rxd = 1'b1;
        if (upd) model_byte(b, stop_ok);
    endtask

    task automatic pop();
        rd_pop = 1'b1;
        idle(1);
        rd_pop = 1'b0;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic status(input string n);
        chk({n, "_valid"}, rx_valid, model_q.size() != 0);
        chk({n, "_full"}, rx_full, model_q.size() == DEPTH);
        chk({n, "_ferr"}, framing_err, exp_ferr);
        chk({n, "_ovf"}, overflow, exp_ovf);
        chk({n, "_data"}, rx_data, model_q.size() != 0 ? model_q[0] : 8'h00);
    endtask

    // Monitor: every accepted read is checked against the model queue head.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rd_pop && !rst) begin
            if (model_q.size() == 0) begin
                chk("pop_empty_valid", rx_valid, 0);
                chk("pop_empty_data", rx_data, 0);
            end else begin
                exp_b = model_q.pop_front();
                chk("pop_valid", rx_valid, 1);
                chk("pop_data", rx_data, exp_b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        real        cpb;
        repeat (3) @(posedge clk);
        #1;
        status("reset");
        rst = 1'b0;
        idle(5);

        fork
            send_frame(8'hA5, 1'b1, 27.0, 0, 1'b1);
            begin
                repeat (T_STOP - 1) @(posedge clk);
                @(negedge clk);
                chk("a5_before_stop", rx_valid, 0);
                @(negedge clk);
                chk("a5_after_stop", rx_valid, 1);
                chk("a5_data_early", rx_data, 8'hA5);
            end
        join
        status("a5");
        pop();
        status("a5_popped");
        idle(5);

        uart_rxd = 1'b0;
        idle(5);
        uart_rxd = 1'b1;
        idle(3 * CPB);
        status("glitch");

        send_frame(8'h3C, 1'b0, 27.0, 2 * CPB, 1'b1);
        idle(CPB);
        status("ferr");
        send_frame(8'h55, 1'b1, 27.0, 0, 1'b1);
        idle(2);
        status("ferr_55");
        clr();
        status("ferr_clr");
        pop();
        status("ferr_popped");

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 27.0, 0, 1'b1);
        idle(2);
        status("ovf_full");
        repeat (4) pop();
        status("ovf_drained");
        clr();
        status("ovf_clr");

        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 27.0, 0, 1'b1);
        idle(5);
        status("full_before");
        fork
            send_frame(8'h77, 1'b1, 27.0, 0, 1'b1);
            begin
                repeat (T_STOP - 1) @(posedge clk);
                #1;
                rd_pop = 1'b1;
                idle(1);
                rd_pop = 1'b0;
            end
        join
        idle(2);
        status("same_cycle");
        repeat (4) pop();
        status("same_cycle_drained");

        send_frame(8'hFF, 1'b1, 27.0 * 0.97, 0, 1'b1);
        send_frame(8'hFF, 1'b1, 27.0 * 1.03, 0, 1'b1);
        idle(2);
        status("rate_err");
        repeat (2) pop();
        for (int i = 0; i < 10; i++) begin
            b   = 8'($urandom);
            cpb = 27.0 * (0.97 + real'($urandom_range(0, 60)) / 1000.0);
            send_frame(b, 1'b1, cpb, 0, 1'b1);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) pop();
            status("rand");
        end
        while (model_q.size() != 0) pop();
        clr();
        status("rand_done");

        send_frame(8'h12, 1'b1, 27.0, 0, 1'b1);
        fork
            send_frame(8'hC3, 1'b1, 27.0, 0, 1'b0);
            begin
                idle(100);
                rst = 1'b1;
            end
        join
        idle(2);
        model_q.delete();
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        status("mid_rst");
        rst = 1'b0;
        idle(CPB);
        send_frame(8'h81, 1'b1, 27.0, 0, 1'b1);
        idle(2);
        status("after_rst");
        pop();

        uart_rxd = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        uart_rxd = 1'b1;
        idle(3 * CPB);
        status("rst_low_line");
        send_frame(8'h5A, 1'b1, 27.0, 0, 1'b1);
        idle(2);
        status("rst_low_recover");
        pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
